debug_dump_tx: RTL and testbench

//  Read-back/transmit side of the debug link; counterpart of the program loader that writes instruction memory.

---
 rtl/debug_dump_if.sv | 29 ++
 rtl/debug_dump_tx.sv | 129 ++++++++++++
 tb/tb_debug_dump_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_dump_if.sv
// Debug dump link bundle: register-bank/data-memory read ports, UART tx handshake and dump control.
// The master modport is the dump engine's side; slave is the debug unit / UART side.
interface debug_dump_if #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RBITS       = 5
);
    logic                   i_start;
    logic [ADDR_LENGTH-1:0] i_pc;
    logic [RBITS-1:0]       o_rb_addr;
    logic [DATA_WIDTH-1:0]  i_rb_data;
    logic [ADDR_LENGTH-1:0] o_dm_addr;
    logic [DATA_WIDTH-1:0]  i_dm_data;
    logic [7:0]             o_tx_data;
    logic                   o_tx_start;
    logic                   i_tx_done;
    logic                   o_busy;
    logic                   o_done;

    modport master (
        input  i_start, i_pc, i_rb_data, i_dm_data, i_tx_done,
        output o_rb_addr, o_dm_addr, o_tx_data, o_tx_start, o_busy, o_done
    );

    modport slave (
        output i_start, i_pc, i_rb_data, i_dm_data, i_tx_done,
        input  o_rb_addr, o_dm_addr, o_tx_data, o_tx_start, o_busy, o_done
    );
endinterface

// File: rtl/debug_dump_tx.sv
// Snapshot PC, register bank and the low DM_WORDS data-memory words, and stream them MSB-first to the UART tx.
// Optional trailing XOR checksum byte when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_dump_tx #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RBITS       = 5,
    parameter int BANK_SIZE   = 32,
    parameter int DM_WORDS    = 16
) (
    input  logic         clk,
    input  logic         rst,
    debug_dump_if.master bus
);
    localparam int LAST_IDX = BANK_SIZE + DM_WORDS;
    localparam int IW       = $clog2(LAST_IDX + 1);

    typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT, NEXT, FINISH} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [1:0]             byte_cnt;
    logic [ADDR_LENGTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0]  shift;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [7:0]             csum;
    logic                   csum_phase;
`endif

    // Word index 0 is the PC, 1..BANK_SIZE the registers, the rest data memory.
    function automatic logic [RBITS-1:0] rb_addr_of(input logic [IW-1:0] n);
        if (n != '0 && n <= IW'(BANK_SIZE)) return RBITS'(n - IW'(1));
        return '0;
    endfunction

    function automatic logic [ADDR_LENGTH-1:0] dm_addr_of(input logic [IW-1:0] n);
        if (n > IW'(BANK_SIZE)) return ADDR_LENGTH'(n - IW'(BANK_SIZE + 1)) << 2;
        return '0;
    endfunction

    assign bus.o_tx_data = shift[DATA_WIDTH-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            byte_cnt       <= '0;
            pc_q           <= '0;
            shift          <= '0;
            bus.o_rb_addr  <= '0;
            bus.o_dm_addr  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum           <= '0;
            csum_phase     <= 1'b0;
`endif
        end else begin
            bus.o_tx_start <= 1'b0;
            bus.o_done     <= 1'b0;
            case (state)
                IDLE: if (bus.i_start) begin
                    pc_q          <= bus.i_pc;
                    bus.o_busy    <= 1'b1;
                    idx           <= '0;
                    bus.o_rb_addr <= '0;
                    bus.o_dm_addr <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum          <= '0;
                    csum_phase    <= 1'b0;
`endif
                    state         <= LATCH;
                end
                LATCH: begin
                    if (idx == '0)                   shift <= DATA_WIDTH'(pc_q);
                    else if (idx <= IW'(BANK_SIZE))  shift <= bus.i_rb_data;
                    else                             shift <= bus.i_dm_data;
                    byte_cnt       <= '0;
                    bus.o_tx_start <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    csum  <= csum ^ shift[DATA_WIDTH-1 -: 8];
`endif
                    state <= WAIT;
                end
                WAIT: if (bus.i_tx_done) begin
                    shift    <= shift << 8;
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    if (csum_phase) begin
                        bus.o_done <= 1'b1;
                        state      <= FINISH;
                    end else
`endif
                    if (byte_cnt == 2'd3) begin
                        state <= NEXT;
                    end else begin
                        bus.o_tx_start <= 1'b1;
                        state          <= SEND;
                    end
                end
                NEXT: if (idx == IW'(LAST_IDX)) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    // Checksum goes out through the normal SEND/WAIT path as a one-byte word.
                    shift          <= {csum, {(DATA_WIDTH-8){1'b0}}};
                    csum_phase     <= 1'b1;
                    bus.o_tx_start <= 1'b1;
                    state          <= SEND;
`else
                    bus.o_done     <= 1'b1;
                    state          <= FINISH;
`endif
                end else begin
                    idx           <= idx + IW'(1);
                    bus.o_rb_addr <= rb_addr_of(idx + IW'(1));
                    bus.o_dm_addr <= dm_addr_of(idx + IW'(1));
                    state         <= LATCH;
                end
                FINISH: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: memory models feed the read ports, expected bytes are queued per frame.
module tb_debug_dump_tx;
    localparam int BANK_SIZE = 32;
    localparam int DM_WORDS  = 16;
    localparam int NWORDS    = 1 + BANK_SIZE + DM_WORDS;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = 4 * NWORDS + 1;
`else
    localparam int FRAME_LEN = 4 * NWORDS;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_dump_if #(.ADDR_LENGTH(32), .DATA_WIDTH(32), .RBITS(5)) bus ();

    debug_dump_tx #(.ADDR_LENGTH(32), .DATA_WIDTH(32), .RBITS(5),
                    .BANK_SIZE(BANK_SIZE), .DM_WORDS(DM_WORDS))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] rb_mem [BANK_SIZE];
    logic [31:0] dm_mem [DM_WORDS];
    logic [29:0] dm_word;
    assign dm_word       = bus.o_dm_addr[31:2];
    assign bus.i_rb_data = rb_mem[bus.o_rb_addr];
    assign bus.i_dm_data = (dm_word < 30'(DM_WORDS)) ? dm_mem[dm_word[3:0]] : 32'hBAD0_BAD0;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got [FRAME_LEN];

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) start_cnt++;
        if (bus.o_done === 1'b1) done_cnt++;
    end

    task automatic push_frame(input logic [31:0] pc);
        logic [31:0] w;
        logic [7:0]  x;
        x = 8'h00;
        for (int i = 0; i < NWORDS; i++) begin
            if (i == 0)              w = pc;
            else if (i <= BANK_SIZE) w = rb_mem[i-1];
            else                     w = dm_mem[i-1-BANK_SIZE];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[b*8 +: 8]);
                x ^= w[b*8 +: 8];
            end
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // One dump: delay = cycles from o_tx_start to i_tx_done; stall0 overrides it for byte 0;
    // restart_at pulses i_start during that byte; spur injects i_tx_done in LATCH/NEXT cycles;
    // abort_at asserts rst in WAIT of that byte.
    task automatic run_frame(input logic [31:0] pc, input int delay, input int stall0,
                             input int restart_at, input bit spur, input int abort_at);
        int s0, d0, n, held_err, d;
        bit to;
        logic [7:0] cur, exp_b;
        exp_q.delete();
        push_frame(pc);
        n = 0; held_err = 0;
        bus.i_pc = pc; bus.i_start = 1'b1;
        @(negedge clk);
        s0 = start_cnt; d0 = done_cnt;
        bus.i_start = 1'b0; bus.i_pc = 32'h0;
        checks++;
        if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL busy_on_start got %b exp 1", bus.o_busy); end
        if (spur) bus.i_tx_done = 1'b1;
        while (exp_q.size() > 0) begin
            to = 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (bus.o_tx_start === 1'b1) begin to = 1'b0; break; end
                @(negedge clk);
            end
            if (to) begin
                checks++; errors++;
                $display("FAIL tx_start_timeout byte %0d", n);
                break;
            end
            bus.i_tx_done = 1'b0;
            exp_b = exp_q.pop_front();
            cur = bus.o_tx_data;
            got[n] = cur;
            checks++;
            if (cur !== exp_b) begin errors++; $display("FAIL byte_%0d got %h exp %h", n, cur, exp_b); end
            if (n == abort_at) begin
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                checks++;
                if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_outputs got start=%b busy=%b done=%b exp 0 0 0",
                             bus.o_tx_start, bus.o_busy, bus.o_done);
                end
                @(negedge clk);
                rst = 1'b0;
                s0 = start_cnt;
                repeat (20) @(negedge clk);
                checks++;
                if (done_cnt != d0 || start_cnt != s0 || bus.o_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle got dones=%0d starts=%0d busy=%b exp 0 0 0",
                             done_cnt - d0, start_cnt - s0, bus.o_busy);
                end
                exp_q.delete();
                return;
            end
            d = (n == 0 && stall0 > 0) ? stall0 : delay;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== cur) held_err++;
                if (n == restart_at && k == 0) begin bus.i_start = 1'b1; bus.i_pc = 32'hFFFF_FFFF; end
                else begin bus.i_start = 1'b0; bus.i_pc = 32'h0; end
            end
            bus.i_tx_done = 1'b1;
            @(negedge clk);
            if (!(spur && (n % 4) == 3)) bus.i_tx_done = 1'b0;
            n++;
        end
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.o_done === 1'b1) begin to = 1'b0; break; end
            @(negedge clk);
        end
        bus.i_tx_done = 1'b0;
        checks++;
        if (to) begin errors++; $display("FAIL done_timeout after %0d bytes", n); end
        else if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL busy_at_done got %b exp 1", bus.o_busy); end
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b exp 0", bus.o_busy); end
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt - s0 != FRAME_LEN || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL frame_counts got starts=%0d dones=%0d exp %0d 1", start_cnt - s0, done_cnt - d0, FRAME_LEN);
        end
        checks++;
        if (held_err != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL hold_between_bytes got %0d bad cycles, %0d left exp 0 0", held_err, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 ||
            bus.o_tx_data !== 8'h00 || bus.o_rb_addr !== 5'd0 || bus.o_dm_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got start=%b busy=%b done=%b data=%h rb=%h dm=%h exp all 0",
                     bus.o_tx_start, bus.o_busy, bus.o_done, bus.o_tx_data, bus.o_rb_addr, bus.o_dm_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame;
        for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = $urandom;
        for (int i = 0; i < DM_WORDS; i++) dm_mem[i] = $urandom;
        rb_mem[5] = 32'hDEADBEEF;
        dm_mem[0] = 32'h12345678;
        run_frame(32'h0000_0040, 3, 0, -1, 1'b0, -1);
        checks++;
        if ({got[0], got[1], got[2], got[3]} !== 32'h0000_0040) begin
            errors++; $display("FAIL pc_bytes got %h exp 00000040", {got[0], got[1], got[2], got[3]});
        end
        checks++;
        if ({got[24], got[25], got[26], got[27]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL r5_bytes got %h exp deadbeef", {got[24], got[25], got[26], got[27]});
        end
        checks++;
        if ({got[132], got[133], got[134], got[135]} !== 32'h12345678) begin
            errors++; $display("FAIL dm0_bytes got %h exp 12345678", {got[132], got[133], got[134], got[135]});
        end
    endtask

    task automatic test_restart;
        for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = $urandom;
        run_frame(32'hCAFE_0123, 3, 0, 50, 1'b0, -1);
    endtask

    task automatic test_spurious;
        int s0;
        s0 = start_cnt;
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (start_cnt != s0 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL idle_tx_done got starts=%0d busy=%b exp 0 0", start_cnt - s0, bus.o_busy);
        end
        run_frame(32'h1357_9BDF, 2, 0, -1, 1'b1, -1);
    endtask

    task automatic test_stall;
        run_frame(32'h00AB_CDEF, 1, 1000, -1, 1'b0, -1);
        checks++;
        if (got[0] !== 8'h00) begin errors++; $display("FAIL stall_byte0 got %h exp 00", got[0]); end
    endtask

    task automatic test_midframe_reset;
        run_frame(32'h0BAD_F00D, 3, 0, -1, 1'b0, 10);
    endtask

    task automatic test_checksum;
        logic [7:0] exp_last;
        for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = 32'h0;
        for (int i = 0; i < DM_WORDS; i++) dm_mem[i] = 32'h0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_last = 8'hFF;
`else
        exp_last = 8'h00;
`endif
        run_frame(32'h0000_00FF, 2, 0, -1, 1'b0, -1);
        checks++;
        if (got[FRAME_LEN-1] !== exp_last) begin
            errors++; $display("FAIL last_byte got %h exp %h", got[FRAME_LEN-1], exp_last);
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_pc = 32'h0;
        bus.i_tx_done = 1'b0;
        for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = 32'h0;
        for (int i = 0; i < DM_WORDS; i++) dm_mem[i] = 32'h0;
        test_reset();
        test_frame();
        test_restart();
        test_spurious();
        test_stall();
        test_midframe_reset();
        test_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
